// File: rtl/encoder_scan.sv
// Sequential 8-to-3 encoder: latches a bit-vector on a load strobe, then
// emits the index of every set bit, lowest first, one per valid/ready transfer.
module encoder_scan #(
    parameter int unsigned N = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              e,
    input  logic [2**N-1:0]   D,
    output logic              busy,
    output logic [N-1:0]      a,
    output logic              v,
    input  logic              rdy,
    output logic [N:0]        cnt,
    output logic              done
);

    localparam int unsigned W = 2**N;

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   p_q, p_d;
    logic [N:0]     cnt_q, cnt_d;
    logic           done_q, done_d;

    logic [N-1:0]   low_idx;
    logic [N:0]     pop_d;
    logic [W-1:0]   p_clr;
    logic           xfer;

    // Priority scan from the top down so the lowest set bit wins.
    always_comb begin
        low_idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (p_q[i]) begin
                low_idx = N'(i);
            end
        end
    end

    always_comb begin
        pop_d = '0;
        for (int i = 0; i < W; i++) begin
            pop_d = pop_d + {{N{1'b0}}, D[i]};
        end
    end

    assign xfer  = (state_q == StScan) && rdy;
    assign p_clr = p_q & ~(W'(1) << low_idx);

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (e) begin
                    p_d   = D;
                    cnt_d = pop_d;
                    if (D != '0) begin
                        state_d = StScan;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StScan: begin
                if (xfer) begin
                    p_d   = p_clr;
                    cnt_d = cnt_q - (N+1)'(1);
                    if (p_clr == '0) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            p_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == StScan);
    assign v    = (state_q == StScan);
    assign a    = v ? low_idx : '0;
    assign cnt  = cnt_q;
    assign done = done_q;

endmodule

// File: tb/tb_encoder_scan.sv
// Directed bench for encoder_scan: inputs change 1ns after each rising edge,
// outputs are checked in the same window.
module tb_encoder_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       e;
    logic [7:0] D;
    logic       busy;
    logic [2:0] a;
    logic       v;
    logic       rdy;
    logic [3:0] cnt;
    logic       done;

    int n_chk  = 0;
    int n_pass = 0;

    encoder_scan #(.N(3)) dut (
        .clk  (clk),
        .rst  (rst),
        .e    (e),
        .D    (D),
        .busy (busy),
        .a    (a),
        .v    (v),
        .rdy  (rdy),
        .cnt  (cnt),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic exp_done);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " v"},    32'(v),    32'd0);
        check({tag, " a"},    32'(a),    32'd0);
        check({tag, " cnt"},  32'(cnt),  32'd0);
        check({tag, " done"}, 32'(done), 32'(exp_done));
    endtask

    task automatic check_scan(input string tag, input int exp_a, input int exp_cnt);
        check({tag, " v"},    32'(v),    32'd1);
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " a"},    32'(a),    32'(exp_a));
        check({tag, " cnt"},  32'(cnt),  32'(exp_cnt));
        check({tag, " done"}, 32'(done), 32'd0);
    endtask

    int norm_a[4]   = '{1, 2, 5, 7};
    int norm_cnt[4] = '{4, 3, 2, 1};

    initial begin
        rst = 1'b1;
        e   = 1'b1;
        D   = 8'hFF;
        rdy = 1'b1;
        tick();
        tick();
        check_idle("reset", 1'b0);

        // Normal drain of 1010_0110
        rst = 1'b0;
        e   = 1'b1;
        D   = 8'b1010_0110;
        tick();
        e = 1'b0;
        D = 8'h00;
        for (int i = 0; i < 4; i++) begin
            check_scan("drain", norm_a[i], norm_cnt[i]);
            tick();
        end
        check_idle("drain end", 1'b1);
        tick();
        check("drain pulse width", 32'(done), 32'd0);

        // Backpressure
        rdy = 1'b0;
        e   = 1'b1;
        D   = 8'b1000_0001;
        tick();
        e = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_scan("stall", 0, 2);
            tick();
        end
        rdy = 1'b1;
        check_scan("release", 0, 2);
        tick();
        check_scan("release", 7, 1);
        tick();
        check_idle("release end", 1'b1);
        tick();

        // Zero vector
        e = 1'b1;
        D = 8'h00;
        tick();
        e = 1'b0;
        check_idle("zero", 1'b1);
        tick();
        check_idle("zero after", 1'b0);

        // Load ignored during SCAN, then back-to-back load in done cycle
        e = 1'b1;
        D = 8'hFF;
        tick();
        for (int i = 0; i < 8; i++) begin
            check_scan("full", i, 8 - i);
            e = (i == 1);
            D = 8'h01;
            tick();
        end
        check_idle("full end", 1'b1);
        e = 1'b1;
        D = 8'h10;
        tick();
        e = 1'b0;
        check_scan("b2b", 4, 1);
        tick();
        check_idle("b2b end", 1'b1);
        tick();

        // Reset mid-SCAN
        e = 1'b1;
        D = 8'hFF;
        tick();
        e = 1'b0;
        tick();
        tick();
        check_scan("pre-rst", 2, 6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("mid rst", 1'b0);
        tick();
        check_idle("post rst", 1'b0);
        e = 1'b1;
        D = 8'h80;
        tick();
        e = 1'b0;
        check_scan("after rst", 7, 1);
        tick();
        check_idle("after rst end", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
